// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM single-port memory arbiter: FSM states, requester ids,
// memory word address and the latency-counter load helper.
package mem_port_arbiter_pkg;

  localparam int MemAddrWidth = 4;
  localparam int LatWidth     = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } ArbState;

  typedef logic [MemAddrWidth-1:0] MemAddr;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } Requester;

  typedef logic [LatWidth-1:0] LatCount;

  // Cycles from issue to ack: reads wait for the memory pipeline, writes retire next cycle.
  function automatic LatCount lat_load_val(input logic is_read, input int read_lat);
    LatCount val;
    if (is_read) begin
      val = LatCount'(read_lat);
    end else begin
      val = LatCount'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// Access latency timer: loaded at issue, counts down once per cycle; done marks the
// cycle in which the count reaches zero (the ack cycle).
module arb_lat_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_i,
  input  LatCount load_val_i,
  output logic    done_o
);

  LatCount cnt_q;
  LatCount cnt_d;

  // Next count: load on issue, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != LatCount'(0)) begin
      cnt_d = cnt_q - LatCount'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LatCount'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LatCount'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (IF) and load/store (MEM) requests onto one single-port memory,
// sequencing each access with a fixed read latency and returning per-requester acks.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_W = MemAddrWidth,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [7:0]            if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

  localparam int StarveW = $clog2(STARVE_MAX + 1);
  typedef logic [StarveW-1:0] starve_t;
  localparam starve_t StarveMax = starve_t'(STARVE_MAX);

  ArbState  state_q;
  ArbState  state_d;
  starve_t  starve_q;
  starve_t  starve_d;
  logic     live_q;
  logic     live_d;
  logic     issue_s;
  Requester grant_s;
  LatCount  lat_load_s;
  logic     lat_done_s;
  logic     if_ack_s;
  logic     d_ack_s;
  logic     unused_addr_bits_s;
  logic [MEM_ADDR_W-1:0] if_word_s;
  logic [MEM_ADDR_W-1:0] d_word_s;

  // Byte addresses fold onto the small word space; high and sub-word bits are dropped.
  assign if_word_s          = if_addr[MEM_ADDR_W+1:2];
  assign d_word_s           = d_addr[MEM_ADDR_W+1:2];
  assign unused_addr_bits_s = ^{if_addr, d_addr};

  // Grant: the older MEM instruction wins unless fetch has been starved long enough.
  always_comb begin
    grant_s = REQ_D;
    if (if_req && (!d_req || (starve_q == StarveMax))) begin
      grant_s = REQ_IF;
    end else begin
      grant_s = REQ_D;
    end
  end

  // FSM next state: issue only from IDLE, ack exactly when the latency timer expires.
  always_comb begin
    state_d  = state_q;
    issue_s  = 1'b0;
    if_ack_s = 1'b0;
    d_ack_s  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (live_q && (if_req || d_req)) begin
          issue_s = 1'b1;
          state_d = (grant_s == REQ_IF) ? ARB_BUSY_I : ARB_BUSY_D;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_I: begin
        if (lat_done_s) begin
          if_ack_s = 1'b1;
          state_d  = ARB_IDLE;
        end else begin
          state_d  = ARB_BUSY_I;
        end
      end
      ARB_BUSY_D: begin
        if (lat_done_s) begin
          d_ack_s = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_BUSY_D;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Starvation counter: counts D grants that bypassed a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (!if_req) begin
      starve_d = starve_t'(0);
    end else if (issue_s && (grant_s == REQ_IF)) begin
      starve_d = starve_t'(0);
    end else if (issue_s && (starve_q != StarveMax)) begin
      starve_d = starve_q + starve_t'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // live_q keeps the command strobe quiet while reset is asserted, even with requests held.
  assign live_d     = 1'b1;
  assign lat_load_s = lat_load_val((grant_s == REQ_IF) || !d_we, READ_LAT);

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= starve_t'(0);
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      live_q   <= live_d;
    end
  end

  arb_lat_timer u_lat_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (issue_s),
    .load_val_i (lat_load_s),
    .done_o     (lat_done_s)
  );

  // Memory command mux: fields are zero whenever no command is issued.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 32'h0000_0000;
    if (issue_s) begin
      if (grant_s == REQ_IF) begin
        mem_addr = if_word_s;
      end else begin
        mem_addr  = d_word_s;
        mem_we    = d_we;
        mem_wdata = d_we ? d_wdata : 32'h0000_0000;
      end
    end else begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = 32'h0000_0000;
    end
  end

  assign mem_en    = issue_s;
  assign if_ack    = if_ack_s;
  assign d_ack     = d_ack_s;
  assign if_rdata  = if_ack_s ? mem_rdata : 32'h0000_0000;
  assign d_rdata   = d_ack_s ? mem_rdata : 32'h0000_0000;
  assign stall_if  = if_req & ~if_ack_s;
  assign stall_mem = d_req & ~d_ack_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory
// commands and acks; a negedge monitor pops and compares each DUT event.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, stall_if, stall_mem;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_addr;

  logic        d_req1, d_we1, d_ack1, mem_en1, mem_we1;
  logic [31:0] d_addr1, d_wdata1, d_rdata1;
  logic [3:0]  mem_addr1;
  logic        unused_if_ack1, unused_stall_if1, unused_stall_mem1;
  logic [31:0] unused_if_rdata1, unused_mem_wdata1;

  mem_port_arbiter #(.MEM_ADDR_W(4), .READ_LAT(RL), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.MEM_ADDR_W(4), .READ_LAT(1), .STARVE_MAX(4)) u_dut_rl1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(8'h00), .if_ack(unused_if_ack1), .if_rdata(unused_if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(unused_mem_wdata1),
    .mem_rdata(32'hC0DE_0001), .stall_if(unused_stall_if1), .stall_mem(unused_stall_mem1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Memory model: preloaded words 0x1000_000i, reads return data RL cycles after issue.
  typedef struct { logic [31:0] data; int due; } rd_t;
  logic [31:0] mem [16];
  rd_t         rd_q [$];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else rd_q.push_back('{mem[mem_addr], cyc + RL});
    end
  end

  initial begin
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      while (rd_q.size() > 0 && rd_q[0].due < cyc) rd_q.delete(0);
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mem_rdata = rd_q[0].data;
        rd_q.delete(0);
      end else begin
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Scoreboard
  typedef enum logic [1:0] {EV_ISSUE = 2'd0, EV_IACK = 2'd1, EV_DACK = 2'd2} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [15:0] cyc;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        chk;
  } ev_t;
  ev_t exp_q [$];

  function automatic ev_t mk_ev(input ev_kind_t k, input int c, input logic we,
                                input logic [3:0] a, input logic [31:0] d, input logic chk);
    ev_t e;
    e.kind = k; e.cyc = 16'(c); e.we = we; e.addr = a; e.data = d; e.chk = chk;
    return e;
  endfunction

  function automatic void expect_ev(input ev_kind_t k, input int c, input logic we,
                                    input logic [3:0] a, input logic [31:0] d, input logic chk);
    exp_q.push_back(mk_ev(k, c, we, a, d, chk));
  endfunction

  task automatic take(input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got %h required no event", act);
    end else begin
      e = exp_q.pop_front();
      act.chk = e.chk;
      if (!e.chk) begin
        act.data = 32'h0;
        e.data   = 32'h0;
      end
      check("scoreboard_event", 64'(act), 64'(e));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) take(mk_ev(EV_ISSUE, cyc, mem_we, mem_addr, mem_wdata, 1'b0));
      if (if_ack) take(mk_ev(EV_IACK, cyc, 1'b0, 4'h0, if_rdata, 1'b0));
      if (d_ack)  take(mk_ev(EV_DACK, cyc, 1'b0, 4'h0, d_rdata, 1'b0));
    end
  end

  // Requester agents: hold the request until ack, release at the following edge.
  task automatic do_fetch(input logic [7:0] a);
    bit seen = 1'b0;
    if_addr = a;
    if_req  = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if_ack) seen = 1'b1;
    end
    check("if_ack_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bit seen = 1'b0;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (d_ack) seen = 1'b1;
    end
    check("d_ack_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  int t;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 8'h0C; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h14;
    d_wdata = 32'hFFFF_FFFF;
    d_req1 = 1'b0; d_we1 = 1'b0; d_addr1 = 32'h0; d_wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_en, mem_we, if_ack, d_ack, mem_addr, mem_wdata, if_rdata},
          68'h0);
    check("reset_stalls", {62'h0, stall_if, stall_mem}, 64'h3);
    @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a D load: strobes drop at once, late read data is ignored
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b0, 4'h2, 32'h0, 1'b0);
    d_we = 1'b0; d_addr = 32'h08; d_req = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_access", {60'h0, mem_en, mem_we, d_ack, if_ack}, 64'h0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b0, 4'h2, 32'h0, 1'b0);
    expect_ev(EV_DACK, t + 2, 1'b0, 4'h0, 32'h1000_0002, 1'b1);
    do_data(1'b0, 32'h08, 32'h0);

    // Lone fetch
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b0, 4'h3, 32'h0, 1'b0);
    expect_ev(EV_IACK, t + 2, 1'b0, 4'h0, 32'h1000_0003, 1'b1);
    do_fetch(8'h0C);

    // Store, then a load of the same word at the earliest next issue slot
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b1, 4'h5, 32'hDEAD_BEEF, 1'b1);
    expect_ev(EV_DACK, t + 1, 1'b0, 4'h0, 32'h0, 1'b0);
    expect_ev(EV_ISSUE, t + 2, 1'b0, 4'h5, 32'h0, 1'b0);
    expect_ev(EV_DACK, t + 4, 1'b0, 4'h0, 32'hDEAD_BEEF, 1'b1);
    do_data(1'b1, 32'h14, 32'hDEAD_BEEF);
    do_data(1'b0, 32'h14, 32'h0);

    // Simultaneous requests: D first, fetch stalled until ack+1
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b0, 4'h9, 32'h0, 1'b0);
    expect_ev(EV_DACK, t + 2, 1'b0, 4'h0, 32'h1000_0009, 1'b1);
    expect_ev(EV_ISSUE, t + 3, 1'b0, 4'h8, 32'h0, 1'b0);
    expect_ev(EV_IACK, t + 5, 1'b0, 4'h0, 32'h1000_0008, 1'b1);
    fork
      do_data(1'b0, 32'h24, 32'h0);
      do_fetch(8'h20);
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("stall_pattern", {62'h0, stall_if, stall_mem},
                {62'h0, (k < 5) ? 1'b1 : 1'b0, (k < 2) ? 1'b1 : 1'b0});
        end
      end
    join

    // Starvation: four back-to-back D stores, then the waiting fetch is forced
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_ev(EV_ISSUE, t + 2 * i, 1'b1, 4'(10 + i), 32'h5500_0000 + 32'(i), 1'b1);
      expect_ev(EV_DACK, t + 2 * i + 1, 1'b0, 4'h0, 32'h0, 1'b0);
    end
    expect_ev(EV_ISSUE, t + 8, 1'b0, 4'h1, 32'h0, 1'b0);
    expect_ev(EV_IACK, t + 10, 1'b0, 4'h0, 32'h1000_0001, 1'b1);
    expect_ev(EV_ISSUE, t + 11, 1'b1, 4'he, 32'h5500_0004, 1'b1);
    expect_ev(EV_DACK, t + 12, 1'b0, 4'h0, 32'h0, 1'b0);
    fork
      do_fetch(8'h04);
      begin
        for (int i = 0; i < 5; i++) do_data(1'b1, 32'h28 + 32'(4 * i), 32'h5500_0000 + 32'(i));
      end
    join

    // Address wrap on the main instance
    t = cyc;
    expect_ev(EV_ISSUE, t, 1'b0, 4'h0, 32'h0, 1'b0);
    expect_ev(EV_DACK, t + 2, 1'b0, 4'h0, 32'h1000_0000, 1'b1);
    do_data(1'b0, 32'hFFFF_FF40, 32'h0);

    // Address wrap with single-cycle read latency
    d_addr1 = 32'hFFFF_FF40; d_we1 = 1'b0; d_req1 = 1'b1;
    @(negedge clk);
    check("rl1_issue", {57'h0, mem_en1, mem_we1, d_ack1, mem_addr1}, {57'h0, 3'b100, 4'h0});
    @(negedge clk);
    check("rl1_ack", {30'h0, d_ack1, mem_en1, d_rdata1}, {30'h0, 2'b10, 32'hC0DE_0001});
    @(posedge clk);
    #1;
    d_req1 = 1'b0;
    @(negedge clk);
    check("rl1_no_reissue", {63'h0, mem_en1}, 64'h0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
